// File: rtl/prio_vector_capture.sv
// rtl/prio_vector_capture.sv - qualifies 8-line priority encoder outputs into a held interrupt vector
// Two-flop synchronises the encoder, debounces the winning code, presents it over valid/ack.
module prio_vector_capture #(
   parameter int unsigned STABLE_CYCLES = 3,
   parameter logic [7:0]  VEC_BASE      = 8'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       A2,
   input  logic       A1,
   input  logic       A0,
   input  logic       GS,
   input  logic       EO,
   output logic       EI_n,
   output logic [7:0] vec,
   output logic       vec_valid,
   input  logic       ack,
   output logic       missed,
   input  logic       clr_missed,
   output logic       idle
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, QUALIFY, PRESENT, RELEASE} stateT;

   stateT      state;
   logic [2:0] s1Code, s2Code, cand, missCand;
   logic       s1Gs, s2Gs, s1Eo, s2Eo;
   logic [3:0] count, missCount, missNext;
   logic       watching, missHit;

   // Second qualifier: watches for a different request while one is already held
   always_comb begin
      missNext = 4'd1;
      if (missCount != 4'd0 && s2Code == missCand)
         missNext = (missCount == STABLE) ? STABLE : missCount + 4'd1;
      watching = (state == PRESENT || state == RELEASE) && !s2Gs && enable && (s2Code != cand);
      missHit  = watching && (missNext == STABLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Code    <= 3'd0;
         s2Code    <= 3'd0;
         s1Gs      <= 1'b1;
         s2Gs      <= 1'b1;
         s1Eo      <= 1'b1;
         s2Eo      <= 1'b1;
         state     <= IDLE;
         cand      <= 3'd0;
         count     <= 4'd0;
         missCand  <= 3'd0;
         missCount <= 4'd0;
         vec       <= VEC_BASE;
         vec_valid <= 1'b0;
         missed    <= 1'b0;
         idle      <= 1'b0;
         EI_n      <= 1'b1;
      end else begin
         s1Code <= {A2, A1, A0};
         s1Gs   <= GS;
         s1Eo   <= EO;
         s2Code <= s1Code;
         s2Gs   <= s1Gs;
         s2Eo   <= s1Eo;

         EI_n <= ~enable;
         idle <= !s2Eo && s2Gs;

         if (watching) begin
            missCand  <= s2Code;
            missCount <= missNext;
         end else begin
            missCount <= 4'd0;
         end

         if (missHit)
            missed <= 1'b1;
         else if (clr_missed)
            missed <= 1'b0;

         case (state)
            IDLE: begin
               if (!s2Gs && enable) begin
                  cand  <= s2Code;
                  count <= 4'd1;
                  if (STABLE == 4'd1) begin
                     vec       <= VEC_BASE + {5'b0, s2Code};
                     vec_valid <= 1'b1;
                     state     <= PRESENT;
                  end else begin
                     state <= QUALIFY;
                  end
               end
            end
            QUALIFY: begin
               if (s2Gs || !enable) begin
                  count <= 4'd0;
                  state <= IDLE;
               end else if (s2Code != cand) begin
                  cand  <= s2Code;
                  count <= 4'd1;
               end else if (count + 4'd1 == STABLE) begin
                  count     <= STABLE;
                  vec       <= VEC_BASE + {5'b0, cand};
                  vec_valid <= 1'b1;
                  state     <= PRESENT;
               end else begin
                  count <= count + 4'd1;
               end
            end
            PRESENT: begin
               if (ack && vec_valid) begin
                  vec_valid <= 1'b0;
                  state     <= RELEASE;
               end
            end
            RELEASE: begin
               // Hold off until the accepted level request is withdrawn
               if (s2Gs || s2Code != cand)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_vector_capture.sv
// tb/tb_prio_vector_capture.sv - table-driven bench for prio_vector_capture
module tb_prio_vector_capture;

   typedef struct {
      logic       rst, en, gs, eo;
      logic [2:0] code;
      logic       ack, clr;
      logic       expVv;
      logic [7:0] expVec;
      logic       expMissed, expIdle, expEin;
   } rowT;

   logic       clk = 1'b0;
   logic       rst, enable, gs, eo, ack, clrMissed;
   logic [2:0] code;
   logic       einA, vvA, missedA, idleA;
   logic [7:0] vecA;
   logic       einB, vvB, missedB, idleB;
   logic [7:0] vecB;

   int checks = 0;
   int failures = 0;
   rowT tbl[$];

   always #5 clk = ~clk;

   prio_vector_capture dutA (
      .clk(clk), .rst(rst), .enable(enable),
      .A2(code[2]), .A1(code[1]), .A0(code[0]),
      .GS(gs), .EO(eo), .EI_n(einA), .vec(vecA), .vec_valid(vvA),
      .ack(ack), .missed(missedA), .clr_missed(clrMissed), .idle(idleA)
   );

   prio_vector_capture #(.STABLE_CYCLES(1), .VEC_BASE(8'hFC)) dutB (
      .clk(clk), .rst(rst), .enable(enable),
      .A2(code[2]), .A1(code[1]), .A0(code[0]),
      .GS(gs), .EO(eo), .EI_n(einB), .vec(vecB), .vec_valid(vvB),
      .ack(ack), .missed(missedB), .clr_missed(clrMissed), .idle(idleB)
   );

   function automatic rowT mk(logic r, logic e, logic g, logic o, logic [2:0] c, logic a, logic cl,
                              logic v, logic [7:0] vc, logic m, logic i, logic ein);
      rowT x;
      x.rst = r; x.en = e; x.gs = g; x.eo = o; x.code = c; x.ack = a; x.clr = cl;
      x.expVv = v; x.expVec = vc; x.expMissed = m; x.expIdle = i; x.expEin = ein;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; gs = 1'b0; eo = 1'b1; code = 3'd5; ack = 1'b0; clrMissed = 1'b0;

      // reset during an active request, then basic capture of code 5
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1,1,0,1,3'd5,0,0, 0,8'h20,0,0,1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,0,1,3'd5,0,0, 0,8'h20,0,0,0));
      tbl.push_back(mk(0,1,0,1,3'd5,0,0, 1,8'h25,0,0,0));
      tbl.push_back(mk(0,1,0,1,3'd5,1,0, 0,8'h25,0,0,0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,0,1,3'd5,0,0, 0,8'h25,0,0,0));
      // request withdrawn with EO low: idle after three edges
      for (int i = 0; i < 2; i++) tbl.push_back(mk(0,1,1,0,3'd0,0,0, 0,8'h25,0,0,0));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(0,1,1,0,3'd0,0,0, 0,8'h25,0,1,0));
      // glitch: code 3 for two cycles, then code 6 held
      for (int i = 0; i < 2; i++) tbl.push_back(mk(0,1,0,1,3'd3,0,0, 0,8'h25,0,1,0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,0,1,3'd6,0,0, 0,8'h25,0,0,0));
      tbl.push_back(mk(0,1,0,1,3'd6,0,0, 1,8'h26,0,0,0));
      // missed: code 4 stable while 6 pending; clear loses against a live set
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,0,1,3'd4,0,0, 1,8'h26,0,0,0));
      tbl.push_back(mk(0,1,0,1,3'd4,0,0, 1,8'h26,1,0,0));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(0,1,0,1,3'd6,0,1, 1,8'h26,1,0,0));
      tbl.push_back(mk(0,1,0,1,3'd6,0,1, 1,8'h26,0,0,0));
      tbl.push_back(mk(0,1,0,1,3'd6,0,0, 1,8'h26,0,0,0));
      tbl.push_back(mk(0,1,0,1,3'd6,1,0, 0,8'h26,0,0,0));
      tbl.push_back(mk(0,1,0,1,3'd6,0,0, 0,8'h26,0,0,0));
      // release, start qualifying code 1, then drop enable mid-window
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,1,3'd6,0,0, 0,8'h26,0,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,1,3'd1,0,0, 0,8'h26,0,0,0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,1,3'd1,0,0, 0,8'h26,0,0,1));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; enable = tbl[i].en; gs = tbl[i].gs; eo = tbl[i].eo;
         code = tbl[i].code; ack = tbl[i].ack; clrMissed = tbl[i].clr;
         step();
         check($sformatf("row%0d vec_valid", i), 32'(vvA), 32'(tbl[i].expVv));
         check($sformatf("row%0d vec", i), 32'(vecA), 32'(tbl[i].expVec));
         check($sformatf("row%0d missed", i), 32'(missedA), 32'(tbl[i].expMissed));
         check($sformatf("row%0d idle", i), 32'(idleA), 32'(tbl[i].expIdle));
         check($sformatf("row%0d EI_n", i), 32'(einA), 32'(tbl[i].expEin));
      end

      // wrap with VEC_BASE=FC, STABLE_CYCLES=1: code 7 -> 03 after edge k+2
      rst = 1'b1; enable = 1'b1; gs = 1'b1; eo = 1'b1; code = 3'd0; ack = 1'b0; clrMissed = 1'b0;
      step();
      check("wrap reset vec", 32'(vecB), 32'h0FC);
      check("wrap reset valid", 32'(vvB), 32'd0);
      rst = 1'b0; gs = 1'b0; code = 3'd7;
      step();
      check("wrap k valid", 32'(vvB), 32'd0);
      step();
      check("wrap k+1 valid", 32'(vvB), 32'd0);
      step();
      check("wrap k+2 valid", 32'(vvB), 32'd1);
      check("wrap k+2 vec", 32'(vecB), 32'h003);
      check("default k+2 valid", 32'(vvA), 32'd0);
      step();
      step();
      check("default k+4 valid", 32'(vvA), 32'd1);
      check("default k+4 vec", 32'(vecA), 32'h027);

      // ack together with an already-synchronised new code: immediate release, full requalify
      code = 3'd4;
      step();
      step();
      ack = 1'b1;
      step();
      check("ack drops valid", 32'(vvA), 32'd0);
      // ack held outside PRESENT must be ignored
      step();
      check("requal e4 valid", 32'(vvA), 32'd0);
      step();
      check("requal e5 valid", 32'(vvA), 32'd0);
      step();
      check("requal e6 valid", 32'(vvA), 32'd0);
      ack = 1'b0;
      step();
      check("requal e7 valid", 32'(vvA), 32'd1);
      check("requal e7 vec", 32'(vecA), 32'h024);

      // reset mid-presentation drops the pending vector
      rst = 1'b1;
      step();
      check("midreset valid", 32'(vvA), 32'd0);
      check("midreset vec", 32'(vecA), 32'h020);
      check("midreset EI_n", 32'(einA), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
